// File: rtl/br_channel_controller_if.sv
// B-channel bundle for br_channel_controller: W-completion inputs, M00/M01 responses, S00/S01 returns.
// Orphan_Resp_Err is present only when BR_ORPHAN_CHECK_EN is defined.
interface br_channel_controller_if #(
    parameter int unsigned Slaves_Num = 2,
    parameter int unsigned Resp_Width = 2
);
    localparam int unsigned Slaves_ID_Size = (Slaves_Num > 1) ? $clog2(Slaves_Num) : 1;

    logic [Slaves_ID_Size-1:0] Write_Data_Master;
    logic                      Write_Data_Finsh;
    logic [Slaves_ID_Size-1:0] Write_Data_Master2;
    logic                      Write_Data_Finsh2;
    logic                      Resp_Queue_Full;
    logic [Resp_Width-1:0]     M00_AXI_bresp;
    logic                      M00_AXI_bvalid;
    logic                      M00_AXI_bready;
    logic [Resp_Width-1:0]     M01_AXI_bresp;
    logic                      M01_AXI_bvalid;
    logic                      M01_AXI_bready;
    logic [Resp_Width-1:0]     S00_AXI_bresp;
    logic                      S00_AXI_bvalid;
    logic                      S00_AXI_bready;
    logic [Resp_Width-1:0]     S01_AXI_bresp;
    logic                      S01_AXI_bvalid;
    logic                      S01_AXI_bready;
`ifdef BR_ORPHAN_CHECK_EN
    logic                      Orphan_Resp_Err;
`endif

    modport master (
        output Write_Data_Master, Write_Data_Finsh, Write_Data_Master2, Write_Data_Finsh2,
        output M00_AXI_bresp, M00_AXI_bvalid, M01_AXI_bresp, M01_AXI_bvalid,
        output S00_AXI_bready, S01_AXI_bready,
`ifdef BR_ORPHAN_CHECK_EN
        input  Orphan_Resp_Err,
`endif
        input  Resp_Queue_Full, M00_AXI_bready, M01_AXI_bready,
        input  S00_AXI_bresp, S00_AXI_bvalid, S01_AXI_bresp, S01_AXI_bvalid
    );

    modport slave (
        input  Write_Data_Master, Write_Data_Finsh, Write_Data_Master2, Write_Data_Finsh2,
        input  M00_AXI_bresp, M00_AXI_bvalid, M01_AXI_bresp, M01_AXI_bvalid,
        input  S00_AXI_bready, S01_AXI_bready,
`ifdef BR_ORPHAN_CHECK_EN
        output Orphan_Resp_Err,
`endif
        output Resp_Queue_Full, M00_AXI_bready, M01_AXI_bready,
        output S00_AXI_bresp, S00_AXI_bvalid, S01_AXI_bresp, S01_AXI_bvalid
    );
endinterface

// File: rtl/br_channel_controller.sv
// Write-response router: per-master FIFOs of source IDs steer M00/M01 B responses to S00/S01.
// Optional sticky orphan-response flag enabled by defining BR_ORPHAN_CHECK_EN.
module br_channel_controller #(
    parameter int unsigned Slaves_Num       = 2,
    parameter int unsigned Slaves_ID_Size   = (Slaves_Num > 1) ? $clog2(Slaves_Num) : 1,
    parameter int unsigned Resp_Queue_Depth = 4,
    parameter int unsigned Resp_Width       = 2
) (
    input logic                    ACLK,
    input logic                    ARESETN,
    br_channel_controller_if.slave bus
);
    localparam int unsigned PtrW = $clog2(Resp_Queue_Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Resp_Queue_Depth);

    typedef enum logic {StEmpty, StFull} hold_state_e;

    logic [1:0]                fin;
    logic [Slaves_ID_Size-1:0] fin_id [2];
    logic [1:0]                m_bvalid;
    logic [Resp_Width-1:0]     m_bresp [2];
    logic [1:0]                m_bready;
    logic [1:0]                s_bready;

    logic [Slaves_ID_Size-1:0] mem_q [2][Resp_Queue_Depth];
    logic [PtrW-1:0]           wr_ptr_q [2];
    logic [PtrW-1:0]           rd_ptr_q [2];
    logic [CntW-1:0]           cnt_q [2];
    logic [CntW-1:0]           cnt_d [2];
    logic [1:0]                push;
    logic [1:0]                req [2];
    logic [1:0][1:0]           grant;  // [slave][master]
    logic                      full_q;

    hold_state_e               state_q [2];
    hold_state_e               state_d [2];
    logic [Resp_Width-1:0]     hold_q [2];
    logic [Resp_Width-1:0]     hold_d [2];
    logic [1:0]                rr_q;   // per slave: index of the favoured master
    logic [1:0]                rr_d;

    assign fin       = {bus.Write_Data_Finsh2, bus.Write_Data_Finsh};
    assign fin_id[0] = bus.Write_Data_Master;
    assign fin_id[1] = bus.Write_Data_Master2;
    assign m_bvalid  = {bus.M01_AXI_bvalid, bus.M00_AXI_bvalid};
    assign m_bresp[0] = bus.M00_AXI_bresp;
    assign m_bresp[1] = bus.M01_AXI_bresp;
    assign s_bready  = {bus.S01_AXI_bready, bus.S00_AXI_bready};

    always_comb begin
        grant    = '0;
        m_bready = '0;
        for (int k = 0; k < 2; k++) begin
            req[k] = '0;
            for (int j = 0; j < 2; j++) begin
                req[k][j] = (cnt_q[k] != '0) && m_bvalid[k] &&
                            (mem_q[k][rd_ptr_q[k]] == Slaves_ID_Size'(j));
            end
        end
        for (int j = 0; j < 2; j++) begin
            // A FULL register draining this cycle can accept a new response without a bubble.
            if (state_q[j] == StEmpty || s_bready[j]) begin
                if (req[0][j] && req[1][j]) begin
                    grant[j][rr_q[j]] = 1'b1;
                end else if (req[0][j]) begin
                    grant[j][0] = 1'b1;
                end else if (req[1][j]) begin
                    grant[j][1] = 1'b1;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            m_bready[k] = grant[0][k] | grant[1][k];
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        for (int j = 0; j < 2; j++) begin
            if (|grant[j]) begin
                state_d[j] = StFull;
                hold_d[j]  = grant[j][1] ? m_bresp[1] : m_bresp[0];
                rr_d[j]    = grant[j][0];
            end else if (state_q[j] == StFull && s_bready[j]) begin
                state_d[j] = StEmpty;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            push[k]  = fin[k] && ((cnt_q[k] != DepthCnt) || m_bready[k]);
            cnt_d[k] = cnt_q[k] + CntW'(push[k]) - CntW'(m_bready[k]);
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
                state_q[k]  <= StEmpty;
                hold_q[k]   <= '0;
            end
            rr_q   <= '0;
            full_q <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
                if (m_bready[k]) rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
                cnt_q[k]   <= cnt_d[k];
                state_q[k] <= state_d[k];
                hold_q[k]  <= hold_d[k];
            end
            rr_q   <= rr_d;
            full_q <= (cnt_d[0] == DepthCnt) || (cnt_d[1] == DepthCnt);
        end
    end

    // Storage carries no reset; counts and pointers alone define validity.
    always_ff @(posedge ACLK) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) mem_q[k][wr_ptr_q[k]] <= fin_id[k];
        end
    end

`ifdef BR_ORPHAN_CHECK_EN
    logic orphan_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            orphan_q <= 1'b0;
        end else if ((m_bvalid[0] && cnt_q[0] == '0) || (m_bvalid[1] && cnt_q[1] == '0)) begin
            orphan_q <= 1'b1;
        end
    end

    assign bus.Orphan_Resp_Err = orphan_q;
`endif

    assign bus.Resp_Queue_Full = full_q;
    assign bus.M00_AXI_bready  = m_bready[0];
    assign bus.M01_AXI_bready  = m_bready[1];
    assign bus.S00_AXI_bvalid  = (state_q[0] == StFull);
    assign bus.S00_AXI_bresp   = hold_q[0];
    assign bus.S01_AXI_bvalid  = (state_q[1] == StFull);
    assign bus.S01_AXI_bresp   = hold_q[1];
endmodule

// File: tb/tb_br_channel_controller.sv
// Directed and randomized bench for br_channel_controller against a queue-based response model.
module tb_br_channel_controller;
    localparam int unsigned Depth = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    br_channel_controller_if #(.Slaves_Num(2), .Resp_Width(2)) bus ();

    br_channel_controller #(
        .Slaves_Num(2),
        .Resp_Queue_Depth(Depth),
        .Resp_Width(2)
    ) dut (
        .ACLK(clk),
        .ARESETN(rstn),
        .bus(bus)
    );

    logic [1:0] fin = '0;
    logic       fin_id [2];
    logic [1:0] mbv = '0;
    logic [1:0] mresp [2];
    logic [1:0] sready = '0;

    assign bus.Write_Data_Finsh   = fin[0];
    assign bus.Write_Data_Finsh2  = fin[1];
    assign bus.Write_Data_Master  = fin_id[0];
    assign bus.Write_Data_Master2 = fin_id[1];
    assign bus.M00_AXI_bvalid     = mbv[0];
    assign bus.M01_AXI_bvalid     = mbv[1];
    assign bus.M00_AXI_bresp      = mresp[0];
    assign bus.M01_AXI_bresp      = mresp[1];
    assign bus.S00_AXI_bready     = sready[0];
    assign bus.S01_AXI_bready     = sready[1];

    int vectors = 0;
    int miscompares = 0;

    // Model state: pending source IDs per master, one held response per slave.
    int         mq [2][$];
    bit [1:0]   hv;
    logic [1:0] hr [2];
    int         rr [2];
    bit         full_m;
    bit         orphan_m;
    bit [1:0]   resp_known;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq[0].delete();
        mq[1].delete();
        hv = '0;
        hr[0] = '0;
        hr[1] = '0;
        rr[0] = 0;
        rr[1] = 0;
        full_m = 1'b0;
        orphan_m = 1'b0;
        resp_known = 2'b11;
    endtask

    // One clock: predict grants from current inputs, compare at negedge, advance model.
    task automatic step();
        int       win [2];
        bit [1:0] exp_rdy;
        bit       r0, r1;
        exp_rdy = '0;
        for (int j = 0; j < 2; j++) begin
            win[j] = -1;
            r0 = (mq[0].size() > 0) && mbv[0] && (mq[0][0] == j);
            r1 = (mq[1].size() > 0) && mbv[1] && (mq[1][0] == j);
            if (!hv[j] || sready[j]) begin
                if (r0 && r1) win[j] = rr[j];
                else if (r0) win[j] = 0;
                else if (r1) win[j] = 1;
            end
            if (win[j] >= 0) exp_rdy[win[j]] = 1'b1;
        end
        @(negedge clk);
        check("s00_bvalid", 32'(bus.S00_AXI_bvalid), 32'(hv[0]));
        check("s01_bvalid", 32'(bus.S01_AXI_bvalid), 32'(hv[1]));
        if (resp_known[0]) check("s00_bresp", 32'(bus.S00_AXI_bresp), 32'(hr[0]));
        if (resp_known[1]) check("s01_bresp", 32'(bus.S01_AXI_bresp), 32'(hr[1]));
        check("queue_full", 32'(bus.Resp_Queue_Full), 32'(full_m));
        if (rstn) check("m_bready", 32'({bus.M01_AXI_bready, bus.M00_AXI_bready}), 32'(exp_rdy));
`ifdef BR_ORPHAN_CHECK_EN
        check("orphan_err", 32'(bus.Orphan_Resp_Err), 32'(orphan_m));
`endif
        if (!rstn) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (mbv[k] && mq[k].size() == 0) orphan_m = 1'b1;
            end
            for (int j = 0; j < 2; j++) begin
                if (win[j] >= 0) begin
                    hv[j] = 1'b1;
                    hr[j] = mresp[win[j]];
                    rr[j] = 1 - win[j];
                    resp_known[j] = 1'b1;
                end else if (hv[j] && sready[j]) begin
                    hv[j] = 1'b0;
                    resp_known[j] = 1'b0;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (exp_rdy[k]) void'(mq[k].pop_front());
                if (fin[k] && mq[k].size() < Depth) mq[k].push_back(int'(fin_id[k]));
            end
            full_m = (mq[0].size() == Depth) || (mq[1].size() == Depth);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        fin_id[0] = 1'b0;
        fin_id[1] = 1'b0;
        mresp[0] = '0;
        mresp[1] = '0;
        model_reset();
        #1;
        step();
        step();
        rstn = 1'b1;
        check("rst_s00_bvalid", 32'(bus.S00_AXI_bvalid), 32'd0);
        check("rst_full", 32'(bus.Resp_Queue_Full), 32'd0);

        // Single completion to S01 with a one-cycle-latency return.
        fin = 2'b01; fin_id[0] = 1'b1; step();
        fin = '0; step();
        mbv = 2'b01; mresp[0] = 2'b00; step();
        check("t1_s01_bvalid", 32'(bus.S01_AXI_bvalid), 32'd1);
        check("t1_s00_bvalid", 32'(bus.S00_AXI_bvalid), 32'd0);
        mbv = '0; sready = 2'b10; step();

        // Simultaneous requests to S00: M00 first, M01 next cycle.
        fin = 2'b11; fin_id[0] = 1'b0; fin_id[1] = 1'b0; step();
        fin = '0; mbv = 2'b11; mresp[0] = 2'b00; mresp[1] = 2'b10; sready = 2'b01; step();
        check("t2_first", 32'(bus.S00_AXI_bresp), 32'd0);
        mbv = 2'b10; step();
        check("t2_second", 32'(bus.S00_AXI_bresp), 32'd2);
        mbv = '0; step();

        // S00 stalls while FULL: output holds, losing master waits.
        fin = 2'b11; step();
        fin = '0; sready = 2'b00; mbv = 2'b11; mresp[0] = 2'b01; mresp[1] = 2'b11; step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_resp", 32'(bus.S00_AXI_bresp), 32'd1);
            check("t3_m01_wait", 32'(bus.M01_AXI_bready), 32'd0);
        end
        sready = 2'b01; step();
        mbv = '0; step();
        step();

        // Fill M00 queue, then push and pop together at full.
        sready = 2'b00; fin_id[0] = 1'b1; fin = 2'b01;
        for (int i = 0; i < 4; i++) step();
        check("t4_full", 32'(bus.Resp_Queue_Full), 32'd1);
        mbv = 2'b01; mresp[0] = 2'b10; step();
        check("t4_full_kept", 32'(bus.Resp_Queue_Full), 32'd1);
        fin = '0; mbv = '0; step();

        // Reset with entries pending and S01 held.
        rstn = 1'b0; step();
        rstn = 1'b1;
        check("t5_s01_bvalid", 32'(bus.S01_AXI_bvalid), 32'd0);
        check("t5_full", 32'(bus.Resp_Queue_Full), 32'd0);
        mbv = 2'b01; step();
        check("t5_no_route", 32'(bus.M00_AXI_bready), 32'd0);
        mbv = 2'b10; step();
`ifdef BR_ORPHAN_CHECK_EN
        check("t6_orphan", 32'(bus.Orphan_Resp_Err), 32'd1);
`endif
        mbv = '0; step();
        check("t6_m01_bready", 32'(bus.M01_AXI_bready), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            fin[0] = ($urandom_range(0, 2) == 0);
            fin[1] = ($urandom_range(0, 2) == 0);
            fin_id[0] = 1'($urandom);
            fin_id[1] = 1'($urandom);
            mbv = 2'($urandom);
            mresp[0] = 2'($urandom);
            mresp[1] = 2'($urandom);
            sready = 2'($urandom);
            rstn = ($urandom_range(0, 199) != 0);
            step();
        end
        rstn = 1'b1;
        fin = '0; mbv = '0; sready = 2'b11;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
